fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the write port of one `fifo` instance between NUM_REQ producers.
- Each producer has a valid/ready/data interface.
- The arbiter grants one producer at a time for a burst of at most BURST_LEN words, forwards its data to the FIFO, and stalls on FIFO full.
- It sits directly in front of `fifo` (data_i/wrreq_i/full_o) in the ingress path.

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/rr_arb_pick.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 99 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter and its round-robin picker.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Index width that stays at least one bit wide for a single-entry vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin picker: first set request after `last`, wrapping modulo n.
module rr_arb_pick
    import fifo_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    // Walk from the farthest candidate back to last+1 so the nearest one wins.
    always_comb begin
        found = 1'b0;
        idx   = last;
        cand  = '0;
        for (int i = N; i >= 1; i--) begin
            cand = IW'((int'(last) + i) % N);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, in bursts of
// up to BURST_LEN words with one idle decision cycle between grants.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DWIDTH    = 8,
    parameter int BURST_LEN = 4,
    localparam int IW = idx_width(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      srst_n_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DWIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [DWIDTH-1:0]         fifo_data_o,
    output logic                      fifo_wrreq_o,
    input  logic                      fifo_full_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic [IW-1:0]             grant_idx_o
);

    localparam int CW = $clog2(BURST_LEN + 1);

    arb_state_e         state;
    logic [IW-1:0]      gidx;
    logic [CW-1:0]      burst_cnt;
    logic [NUM_REQ-1:0] grant_q;
    logic [DWIDTH-1:0]  data_q;
    logic               pick_found;
    logic [IW-1:0]      pick_idx;
    logic               active;
    logic               granted_valid;
    logic               xfer;
    logic               last_burst;
    logic [DWIDTH-1:0]  word_g;

    // gidx doubles as the round-robin "last" pointer while idle.
    rr_arb_pick #(.N(NUM_REQ)) u_pick (
        .req   (req_valid_i),
        .last  (gidx),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Handshake: a word moves when req_valid_i[k] & req_ready_o[k] are both high at the
    // rising edge; the same cycle drives it onto the FIFO write port (zero latency).
    // Ready is only offered to the granted requester, never while full or in reset.
    assign word_g        = req_data_i[int'(gidx)*DWIDTH +: DWIDTH];
    assign granted_valid = req_valid_i[gidx];
    assign active        = srst_n_i && (state == GRANT) && !fifo_full_i;
    assign xfer          = active && granted_valid;
    assign last_burst    = (burst_cnt == CW'(BURST_LEN - 1));

    assign req_ready_o  = active ? grant_q : '0;
    assign fifo_wrreq_o = xfer;
    assign fifo_data_o  = xfer ? word_g : data_q;
    assign grant_o      = grant_q;
    assign grant_idx_o  = gidx;

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state     <= IDLE;
            gidx      <= IW'(NUM_REQ - 1);
            burst_cnt <= '0;
            grant_q   <= '0;
            data_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state     <= GRANT;
                        gidx      <= pick_idx;
                        grant_q   <= NUM_REQ'(1) << pick_idx;
                        burst_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (!granted_valid) begin
                        state   <= IDLE;
                        grant_q <= '0;
                    end else if (xfer) begin
                        data_q    <= word_g;
                        burst_cnt <= burst_cnt + CW'(1);
                        if (last_burst) begin
                            state   <= IDLE;
                            grant_q <= '0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: requester driver, behavioural 16-deep FIFO occupancy model,
// write-side scoreboard monitor, directed scenarios and a random soak.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int DEPTH = 16;

    logic           clk = 1'b0;
    logic           srst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   fifo_data;
    logic           fifo_wrreq;
    logic           fifo_full;
    logic [N-1:0]   grant;
    logic [1:0]     grant_idx;

    int checks   = 0;
    int failures = 0;

    logic [9:0] exp_q[$];
    logic [7:0] exp_rq[N][$];
    logic [7:0] src_q[N][$];

    logic [N-1:0] en;
    logic         force_full;
    logic         rd_en;
    logic         rnd_mode;
    int           used;

    always #5 clk = ~clk;

    assign fifo_full = force_full || (used >= DEPTH);

    fifo_wr_arbiter #(.NUM_REQ(N), .DWIDTH(W), .BURST_LEN(4)) dut (
        .clk_i        (clk),
        .srst_n_i     (srst_n),
        .req_valid_i  (req_valid),
        .req_data_i   (req_data),
        .req_ready_o  (req_ready),
        .fifo_data_o  (fifo_data),
        .fifo_wrreq_o (fifo_wrreq),
        .fifo_full_i  (fifo_full),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task step;
        @(posedge clk);
        #1;
    endtask

    // Requester driver: pop on observed handshake, present queue head while enabled.
    initial begin
        logic [N-1:0] acc;
        req_valid = '0;
        req_data  = '0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #2;
            for (int k = 0; k < N; k++) begin
                if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
                req_valid[k] = en[k] && (src_q[k].size() > 0);
                req_data[k*W +: W] = (src_q[k].size() > 0) ? src_q[k][0] : 8'h00;
            end
        end
    end

    // Monitor and FIFO occupancy model.
    initial begin
        logic w;
        logic r;
        logic [9:0] e;
        used = 0;
        forever begin
            @(negedge clk);
            chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
            if (fifo_wrreq) begin
                chk("no_write_when_full", 32'(fifo_full), 32'd0);
                chk("no_write_in_reset", 32'(srst_n), 32'd1);
                if (rnd_mode) begin
                    if (exp_rq[grant_idx].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rnd_unexpected_write: got req%0d data 0x%0h expected no write", grant_idx, fifo_data);
                    end else begin
                        chk("rnd_word_order", 32'(fifo_data), 32'(exp_rq[grant_idx].pop_front()));
                    end
                end else begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL dir_unexpected_write: got idx %0d data 0x%0h expected no write", grant_idx, fifo_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("dir_write_idx_data", 32'({grant_idx, fifo_data}), 32'(e));
                    end
                end
            end
            w = fifo_wrreq && !fifo_full;
            r = rd_en;
            @(posedge clk);
            #1;
            used = used + (w ? 1 : 0) - ((r && used > 0) ? 1 : 0);
        end
    end

    task automatic load(input int k, input logic [7:0] word);
        src_q[k].push_back(word);
        exp_q.push_back({2'(k), word});
    endtask

    initial begin
        int cyc;
        logic [7:0] rw;
        srst_n = 1'b0;
        en = '0;
        force_full = 1'b0;
        rd_en = 1'b0;
        rnd_mode = 1'b0;
        repeat (3) step;

        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_grant_idx", 32'(grant_idx), 32'd3);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_wrreq", 32'(fifo_wrreq), 32'd0);
        chk("rst_data", 32'(fifo_data), 32'h0);

        // Test 1: lone requester 0, bursts of four then re-grant after one idle cycle.
        step;
        srst_n = 1'b1;
        for (int i = 0; i < 5; i++) load(0, 8'(8'h10 + i));
        en[0] = 1'b1;
        @(negedge clk);
        chk("t1_pre_grant", 32'(grant), 32'h0);
        @(negedge clk);
        chk("t1_grant", 32'(grant), 32'b0001);
        repeat (4) @(negedge clk);
        chk("t1_idle_grant", 32'(grant), 32'h0);
        chk("t1_idle_wrreq", 32'(fifo_wrreq), 32'd0);
        @(negedge clk);
        chk("t1_regrant", 32'(grant), 32'b0001);
        chk("t1_word5", 32'(fifo_data), 32'h14);
        repeat (4) step;
        en = '0;

        // Test 2: all four requesters from reset, rotation 0..3, FIFO fills at 16.
        step;
        srst_n = 1'b0;
        rd_en = 1'b1;
        repeat (8) step;
        srst_n = 1'b1;
        rd_en = 1'b0;
        for (int i = 0; i < 4; i++) load(0, 8'(8'h20 + i));
        for (int i = 0; i < 4; i++) load(1, 8'(8'h40 + i));
        for (int i = 0; i < 4; i++) load(2, 8'(8'h80 + i));
        for (int i = 0; i < 4; i++) load(3, 8'(8'hC0 + i));
        load(0, 8'h24);
        en = 4'b1111;
        cyc = 0;
        while (used < DEPTH && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk("t2_used_full", 32'(used), 32'd16);
        chk("t2_cycles_to_full", 32'(cyc), 32'd21);
        @(negedge clk);
        chk("t2_full_grant", 32'(grant), 32'b0001);
        chk("t2_full_ready", 32'(req_ready), 32'h0);
        chk("t2_full_wrreq", 32'(fifo_wrreq), 32'd0);
        step;
        rd_en = 1'b1;
        repeat (24) step;
        rd_en = 1'b0;
        en = '0;

        // Tests 3/4: req1 stalled by full mid-burst, req2 drops after one word, then req3.
        step;
        for (int i = 0; i < 4; i++) load(1, 8'(8'h48 + i));
        load(2, 8'h88);
        for (int i = 0; i < 4; i++) load(3, 8'(8'hC8 + i));
        en = 4'b1110;
        repeat (3) step;
        force_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_hold_grant", 32'(grant), 32'b0010);
            chk("t3_hold_ready", 32'(req_ready), 32'h0);
            chk("t3_hold_wrreq", 32'(fifo_wrreq), 32'd0);
        end
        step;
        force_full = 1'b0;
        @(negedge clk);
        chk("t3_resume_grant", 32'(grant), 32'b0010);
        chk("t3_resume_data", 32'(fifo_data), 32'h4A);
        @(negedge clk);
        chk("t3_last_grant", 32'(grant), 32'b0010);
        @(negedge clk);
        chk("t3_idle", 32'(grant), 32'h0);
        @(negedge clk);
        chk("t4_grant2", 32'(grant), 32'b0100);
        @(negedge clk);
        chk("t4_drop_grant", 32'(grant), 32'b0100);
        chk("t4_drop_nowrite", 32'(fifo_wrreq), 32'd0);
        @(negedge clk);
        chk("t4_idle", 32'(grant), 32'h0);
        @(negedge clk);
        chk("t4_grant3", 32'(grant), 32'b1000);
        repeat (6) step;
        en = '0;

        // Test 5: reset mid-burst of req3; req0 wins the next decision.
        step;
        src_q[3].push_back(8'hD0);
        src_q[3].push_back(8'hD1);
        src_q[3].push_back(8'hD2);
        src_q[3].push_back(8'hD3);
        exp_q.push_back({2'd3, 8'hD0});
        en[3] = 1'b1;
        repeat (2) step;
        srst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_wrreq", 32'(fifo_wrreq), 32'd0);
        chk("t5_rst_ready", 32'(req_ready), 32'h0);
        step;
        srst_n = 1'b1;
        load(0, 8'h30);
        exp_q.push_back({2'd3, 8'hD1});
        exp_q.push_back({2'd3, 8'hD2});
        exp_q.push_back({2'd3, 8'hD3});
        en[0] = 1'b1;
        @(negedge clk);
        chk("t5_after_rst_grant", 32'(grant), 32'h0);
        chk("t5_after_rst_idx", 32'(grant_idx), 32'd3);
        @(negedge clk);
        chk("t5_first_grant", 32'(grant), 32'b0001);
        repeat (12) step;
        en = '0;
        chk("dir_all_written", 32'(exp_q.size()), 32'd0);

        // Test 6: random valid toggling and FIFO reads, per-requester order check.
        rnd_mode = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            step;
            for (int k = 0; k < N; k++) begin
                en[k] = ($urandom_range(0, 3) != 0);
                if (src_q[k].size() < 2) begin
                    rw = 8'($urandom_range(0, 255));
                    src_q[k].push_back(rw);
                    exp_rq[k].push_back(rw);
                end
            end
            rd_en = ($urandom_range(0, 1) == 1);
        end
        step;
        en = '1;
        rd_en = 1'b1;
        cyc = 0;
        while ((src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()) > 0 && cyc < 300) begin
            step;
            cyc++;
        end
        repeat (4) step;
        for (int k = 0; k < N; k++) chk($sformatf("rnd_drained_req%0d", k), 32'(exp_rq[k].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
